// File: rtl/mario_draw_if.sv
// Command, ROM and VGA signals shared between the level FSM side
// and the Mario draw datapath.
interface mario_draw_if;
    logic        resetAddress;
    logic        drStage1;
    logic        drM;
    logic        erM;
    logic        moveRight;
    logic        writeEn;
    logic [14:0] stage_addr;
    logic [2:0]  stage_data;
    logic [7:0]  sprite_addr;
    logic [2:0]  sprite_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        done;
    logic [7:0]  mario_x;

    modport slave (
        input  resetAddress, drStage1, drM, erM, moveRight, writeEn,
        input  stage_data, sprite_data,
        output stage_addr, sprite_addr,
        output x, y, colour, plot, done, mario_x
    );

    modport master (
        output resetAddress, drStage1, drM, erM, moveRight, writeEn,
        output stage_data, sprite_data,
        input  stage_addr, sprite_addr,
        input  x, y, colour, plot, done, mario_x
    );
endinterface

// File: rtl/mario_draw_datapath.sv
// Pixel walker for stage / Mario sprite / erase passes, with a one-stage
// pipeline matched to the ROM latency, plus Mario's x position register.
module mario_draw_datapath #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter int         START_X     = 8,
    parameter int         MARIO_Y     = 88,
    parameter int         STEP        = 4,
    parameter logic [2:0] BG_COLOUR   = 3'b011,
    parameter logic [2:0] TRANSPARENT = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    mario_draw_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STAGE, MARIO, ERASE} mode_t;

    localparam logic [7:0] MAX_X = 8'(SCREEN_W - SPRITE_W);

    mode_t       mode;
    mode_t       last_mode;
    mode_t       tag;
    logic [7:0]  cx;
    logic [6:0]  cy;
    logic [7:0]  lim_x;
    logic [6:0]  lim_y;
    logic        clear;
    logic        advance;
    logic        busy;
    logic        done_r;
    logic        p_valid;
    logic        move_pending;
    logic [7:0]  px;
    logic [6:0]  py;
    logic [7:0]  mario_x;
    logic [8:0]  move_sum;
    logic [7:0]  next_x;

    always_comb begin
        mode = IDLE;
        if (bus.drStage1)
            mode = STAGE;
        else if (bus.drM)
            mode = MARIO;
        else if (bus.erM)
            mode = ERASE;
    end

    always_comb begin
        lim_x = 8'(SPRITE_W - 1);
        lim_y = 7'(SPRITE_H - 1);
        if (mode == STAGE) begin
            lim_x = 8'(SCREEN_W - 1);
            lim_y = 7'(SCREEN_H - 1);
        end
    end

    assign clear   = bus.resetAddress || (mode != last_mode);
    assign advance = (mode != IDLE) && bus.writeEn && !done_r && !clear;
    // Sprite passes block moves so the sprite never tears mid-draw.
    assign busy    = ((mode == MARIO) || (mode == ERASE)) && !done_r;

    assign move_sum = {1'b0, mario_x} + 9'(STEP);
    assign next_x   = (move_sum > {1'b0, MAX_X}) ? MAX_X : move_sum[7:0];

    assign bus.stage_addr  = ({8'd0, cy} << 7) + ({8'd0, cy} << 5)
                           + {7'd0, cx};
    assign bus.sprite_addr = {cy[3:0], cx[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            last_mode    <= IDLE;
            tag          <= IDLE;
            cx           <= '0;
            cy           <= '0;
            done_r       <= 1'b0;
            p_valid      <= 1'b0;
            px           <= '0;
            py           <= '0;
            mario_x      <= 8'(START_X);
            move_pending <= 1'b0;
        end else begin
            last_mode <= mode;
            p_valid   <= advance;
            if (advance) begin
                tag <= mode;
                if (mode == STAGE) begin
                    px <= cx;
                    py <= cy;
                end else begin
                    px <= mario_x + cx;
                    py <= 7'(MARIO_Y) + cy;
                end
            end

            if (clear) begin
                cx     <= '0;
                cy     <= '0;
                done_r <= 1'b0;
            end else if (advance) begin
                if (cx == lim_x) begin
                    if (cy == lim_y) begin
                        done_r <= 1'b1;
                    end else begin
                        cx <= '0;
                        cy <= cy + 7'd1;
                    end
                end else begin
                    cx <= cx + 8'd1;
                end
            end

            if (!busy) begin
                if (bus.moveRight || move_pending)
                    mario_x <= next_x;
                move_pending <= 1'b0;
            end else if (bus.moveRight) begin
                move_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.colour = 3'b000;
        unique case (tag)
            STAGE:   bus.colour = bus.stage_data;
            MARIO:   bus.colour = bus.sprite_data;
            ERASE:   bus.colour = BG_COLOUR;
            default: bus.colour = 3'b000;
        endcase
    end

    assign bus.plot    = p_valid &&
                         ((tag != MARIO) || (bus.sprite_data != TRANSPARENT));
    assign bus.x       = px;
    assign bus.y       = py;
    assign bus.done    = done_r;
    assign bus.mario_x = mario_x;
endmodule

// File: tb/tb_mario_draw_datapath.sv
// Random-ROM bench for mario_draw_datapath: each pass is compared against
// the ordered list of pixels the screen/sprite rules say should appear.
module tb_mario_draw_datapath;
    logic clk;
    logic reset;
    mario_draw_if bus ();

    mario_draw_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic [2:0] stage_rom [32768];
    logic [2:0] sprite_rom [256];
    int total;
    int bad;
    int mx;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.stage_data  <= stage_rom[bus.stage_addr];
        bus.sprite_data <= sprite_rom[bus.sprite_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int m);
        bus.drStage1 = (m == 1);
        bus.drM      = (m == 2);
        bus.erM      = (m == 3);
    endtask

    // m: 1 stage, 2 sprite, 3 erase
    task automatic run_pass(input int m, input bit toggle, input int mv_at,
                            input int budget, output int cycles);
        pix_t q[$];
        pix_t p;
        int w;
        int h;
        bit fin;
        w = (m == 1) ? 160 : 16;
        h = (m == 1) ? 120 : 16;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                if (m == 1) begin
                    p.x = 8'(xx);
                    p.y = 7'(yy);
                    p.c = stage_rom[yy * 160 + xx];
                    q.push_back(p);
                end else begin
                    p.x = 8'(mx + xx);
                    p.y = 7'(88 + yy);
                    p.c = (m == 2) ? sprite_rom[yy * 16 + xx] : 3'b011;
                    if (m == 3 || p.c != 3'b111)
                        q.push_back(p);
                end
            end
        end
        set_cmd(m);
        bus.writeEn      = 1'b1;
        bus.resetAddress = 1'b1;
        bus.moveRight    = 1'b0;
        cycles = 0;
        fin = 0;
        while (!fin && cycles < budget) begin
            @(negedge clk);
            cycles++;
            bus.resetAddress = 1'b0;
            if (cycles == 1)
                chk("done_clear", 32'(bus.done), 0);
            if (mv_at > 0)
                chk("mx_hold", 32'(bus.mario_x), 32'(mx));
            if (bus.plot) begin
                chk("plot_expected", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    p = q.pop_front();
                    chk("px", 32'(bus.x), 32'(p.x));
                    chk("py", 32'(bus.y), 32'(p.y));
                    chk("pc", 32'(bus.colour), 32'(p.c));
                end
            end
            bus.moveRight = (cycles == mv_at);
            if (bus.done)
                fin = 1;
            else if (toggle)
                bus.writeEn = ~bus.writeEn;
        end
        bus.moveRight = 1'b0;
        chk("pass_done", 32'(fin), 1);
        chk("pixels_left", 32'(q.size()), 0);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32768; i++)
            stage_rom[i] = 3'($urandom);
        for (int i = 0; i < 256; i++)
            sprite_rom[i] = 3'($urandom);
        sprite_rom[5] = 3'b111;
        sprite_rom[0] = 3'b010;
        bus.resetAddress = 0;
        bus.moveRight    = 0;
        bus.writeEn      = 0;
        set_cmd(0);
        reset = 1'b1;
        mx = 8;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(bus.x), 0);
        chk("rst_y", 32'(bus.y), 0);
        chk("rst_colour", 32'(bus.colour), 0);
        chk("rst_plot", 32'(bus.plot), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_mx", 32'(bus.mario_x), 8);
        chk("rst_saddr", 32'(bus.stage_addr), 0);
        chk("rst_spaddr", 32'(bus.sprite_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        run_pass(1, 0, 0, 20000, cyc);
        repeat (3) begin
            @(negedge clk);
            chk("stage_done_hold", 32'(bus.done), 1);
            chk("stage_idle_plot", 32'(bus.plot), 0);
        end

        run_pass(2, 0, 0, 400, cyc);
        run_pass(3, 0, 0, 400, cyc);

        run_pass(2, 0, 20, 400, cyc);
        mx = (mx + 4 > 144) ? 144 : mx + 4;
        @(negedge clk);
        chk("move_applied", 32'(bus.mario_x), 32'(mx));

        run_pass(2, 1, 0, 700, cyc);
        chk("toggle_cycles_lo", 32'(cyc >= 505), 1);
        chk("toggle_cycles_hi", 32'(cyc <= 520), 1);

        set_cmd(0);
        bus.writeEn = 0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            bus.moveRight = 1'b1;
            @(negedge clk);
            bus.moveRight = 1'b0;
            mx = (mx + 4 > 144) ? 144 : mx + 4;
            chk("idle_move", 32'(bus.mario_x), 32'(mx));
            @(negedge clk);
        end

        set_cmd(1);
        bus.writeEn = 1'b1;
        bus.resetAddress = 1'b1;
        n = 0;
        for (int i = 0; i < 1000 && n < 500; i++) begin
            @(negedge clk);
            bus.resetAddress = 1'b0;
            if (bus.plot)
                n++;
        end
        chk("reach_500", 32'(n), 500);
        reset = 1'b1;
        mx = 8;
        @(negedge clk);
        chk("abort_plot", 32'(bus.plot), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_mx", 32'(bus.mario_x), 8);
        reset = 1'b0;
        run_pass(1, 0, 0, 20000, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
